// File: rtl/xy_step_scheduler.sv
// Two-axis Bresenham step sequencer: accepts one relative (dx, dy) move and
// emits counted, coordinated step/direction pulses for the X and Y drivers.
// Step, done, aborted and cmd_ready are registered from the FSM state, so they
// appear one clock after the state that produces them.
module xy_step_scheduler #(
  parameter int STEP_W      = 16,
  parameter int STEP_PERIOD = 1000,
  parameter int PULSE_WIDTH = 100,
  parameter int DIR_SETUP   = 10
) (
  input  logic            clock_in,
  input  logic            resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [STEP_W:0] cmd_dx,
  input  logic [STEP_W:0] cmd_dy,
  input  logic            abort,
  output logic            step_x,
  output logic            dir_x,
  output logic            step_y,
  output logic            dir_y,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [STEP_W:0] steps_left
);

  localparam int CNT_MAX = (STEP_PERIOD > DIR_SETUP) ? STEP_PERIOD : DIR_SETUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STEP_PERIOD - PULSE_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_GAP, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STEP_W+1:0]   err_q, err_d;
  logic                hit_q, hit_d;
  logic [STEP_W:0]     left_q, left_d;
  logic                dir_x_q, dir_x_d;
  logic                dir_y_q, dir_y_d;
  logic                pend_q, pend_d;
  logic                step_x_q, step_x_d;
  logic                step_y_q, step_y_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                ready_q, ready_d;
  logic [STEP_W:0]     major_q, major_d;
  logic [STEP_W:0]     minor_q, minor_d;
  logic                x_major_q, x_major_d;

  logic [STEP_W:0]     mag_x, mag_y;
  logic [STEP_W+1:0]   err_sum, major_ext;
  logic                accept;
  logic                enter_pulse;

  // Two's-complement magnitude; STEP_W+1 bits so the most negative input is legal.
  function automatic logic [STEP_W:0] magnitude(input logic [STEP_W:0] v);
    return v[STEP_W] ? (~v + 1'b1) : v;
  endfunction

  assign mag_x     = magnitude(cmd_dx);
  assign mag_y     = magnitude(cmd_dy);
  assign accept    = cmd_valid && ready_q && (state_q == S_IDLE);
  assign err_sum   = err_q + {1'b0, minor_q};
  assign major_ext = {1'b0, major_q};

  // Next-state logic: move sequencing, Bresenham error update, abort handling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    err_d       = err_q;
    hit_d       = hit_q;
    left_d      = left_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    pend_d      = pend_q;
    major_d     = major_q;
    minor_d     = minor_q;
    x_major_d   = x_major_q;
    enter_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_major_d = (mag_x >= mag_y);
          major_d   = x_major_d ? mag_x : mag_y;
          minor_d   = x_major_d ? mag_y : mag_x;
          dir_x_d   = !cmd_dx[STEP_W] && (|cmd_dx);
          dir_y_d   = !cmd_dy[STEP_W] && (|cmd_dy);
          left_d    = major_d;
          err_d     = '0;
          hit_d     = 1'b0;
          pend_d    = 1'b0;
          cnt_d     = '0;
          state_d   = (major_d == '0) ? S_FINISH : S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort) begin
          pend_d  = 1'b1;
          state_d = S_FINISH;
        end else if (cnt_q == SETUP_LAST) begin
          enter_pulse = 1'b1;
        end
      end
      S_PULSE: begin
        // The pulse always runs its full width; a pending abort skips the gap.
        if (abort) pend_d = 1'b1;
        if (cnt_q == PULSE_LAST) begin
          if (abort || pend_q) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_GAP;
            cnt_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          pend_d  = 1'b1;
          state_d = S_FINISH;
        end else if (cnt_q == GAP_LAST) begin
          left_d = left_q - 1'b1;
          if (left_q == {{STEP_W{1'b0}}, 1'b1}) state_d = S_FINISH;
          else                                    enter_pulse = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_pulse) begin
      state_d = S_PULSE;
      cnt_d   = '0;
      if (err_sum >= major_ext) begin
        hit_d = 1'b1;
        err_d = err_sum - major_ext;
      end else begin
        hit_d = 1'b0;
        err_d = err_sum;
      end
    end
  end

  // Registered outputs derived from the current state (glitch-free pins).
  always_comb begin
    step_x_d  = (state_q == S_PULSE) && (x_major_q || hit_q);
    step_y_d  = (state_q == S_PULSE) && (!x_major_q || hit_q);
    done_d    = (state_q == S_FINISH);
    aborted_d = (state_q == S_FINISH) && pend_q;
    ready_d   = (state_q == S_IDLE) && !accept;
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clock_in) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= '0;
      hit_q     <= 1'b0;
      left_q    <= '0;
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      pend_q    <= 1'b0;
      step_x_q  <= 1'b0;
      step_y_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      hit_q     <= hit_d;
      left_q    <= left_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      pend_q    <= pend_d;
      step_x_q  <= step_x_d;
      step_y_q  <= step_y_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      ready_q   <= ready_d;
    end
  end

  // Move geometry latched at accept; only read while a move is active.
  always_ff @(posedge clock_in) begin
    major_q   <= major_d;
    minor_q   <= minor_d;
    x_major_q <= x_major_d;
  end

  assign cmd_ready  = ready_q;
  assign step_x     = step_x_q;
  assign step_y     = step_y_q;
  assign dir_x      = dir_x_q;
  assign dir_y      = dir_y_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = left_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_xy_step_scheduler.sv
// Scoreboard bench for xy_step_scheduler: stimulus pushes hand-computed move
// results, a negedge monitor measures each move and compares on done.
module tb_xy_step_scheduler;

  localparam int SW = 16;
  localparam int SP = 10;
  localparam int PW = 3;
  localparam int DS = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [SW:0]   cmd_dx, cmd_dy;
  logic          abort;
  logic          step_x, dir_x, step_y, dir_y, busy, done, aborted;
  logic [SW:0]   steps_left;

  always #5 clk = ~clk;

  xy_step_scheduler #(
    .STEP_W(SW), .STEP_PERIOD(SP), .PULSE_WIDTH(PW), .DIR_SETUP(DS)
  ) dut (
    .clock_in(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .abort(abort),
    .step_x(step_x), .dir_x(dir_x), .step_y(step_y), .dir_y(dir_y),
    .busy(busy), .done(done), .aborted(aborted), .steps_left(steps_left)
  );

  typedef struct {
    bit ab;
    int nx;
    int ny;
    int mask;
    int lat;
    bit dx;
    bit dy;
    int major;
    int sl_end;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t mk(bit ab, int nx, int ny, int mask, int lat,
                              bit dx, bit dy, int major, int sl_end);
    exp_t e;
    e.ab = ab; e.nx = nx; e.ny = ny; e.mask = mask; e.lat = lat;
    e.dx = dx; e.dy = dy; e.major = major; e.sl_end = sl_end;
    return e;
  endfunction

  // Monitor state
  int   cyc = 0;
  int   acc = 0;
  int   nx = 0, ny = 0, nmax = 0, omax = 0, mask = 0;
  int   hx = 0, hy = 0;
  bit   px = 0, py = 0, rx, ry, chk_rdy = 0;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      nx = 0; ny = 0; omax = 0; mask = 0; hx = 0; hy = 0; chk_rdy = 0;
    end else begin
      if (chk_rdy) begin
        chk("ready_after_done", cmd_ready, 1);
        chk_rdy = 0;
      end
      rx = step_x && !px;
      ry = step_y && !py;
      if (rx) begin
        nx++;
        if (ry && nx <= 32) mask |= (1 << (nx - 1));
      end
      if (ry) ny++;
      if (step_x) hx = rx ? 1 : hx + 1;
      else if (px) chk("pulse_width_x", hx, PW);
      if (step_y) hy = ry ? 1 : hy + 1;
      else if (py) chk("pulse_width_y", hy, PW);
      nmax = (nx > ny) ? nx : ny;
      if (nmax > omax) begin
        chk("major_rise_time", cyc - acc, DS + 1 + (nmax - 1) * SP);
        if (exp_q.size() > 0)
          chk("steps_left_at_rise", steps_left, exp_q[0].major - (nmax - 1));
        omax = nmax;
      end
      if (done) begin
        chk("done_has_expectation", exp_q.size() > 0, 1);
        chk("ready_in_done_cycle", cmd_ready, 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("aborted", aborted, e.ab);
          chk("x_pulses", nx, e.nx);
          chk("y_pulses", ny, e.ny);
          chk("coincident_mask", mask, e.mask);
          chk("done_latency", cyc - acc, e.lat);
          chk("dir_x", dir_x, e.dx);
          chk("dir_y", dir_y, e.dy);
          chk("steps_left_end", steps_left, e.sl_end);
        end
        chk_rdy = 1;
      end
      if (cmd_valid && cmd_ready) begin
        acc = cyc + 1;
        nx = 0; ny = 0; omax = 0; mask = 0;
      end
    end
    px = step_x;
    py = step_y;
  end

  task automatic send(input logic [SW:0] dx, input logic [SW:0] dy,
                      input bit hold, input bit push, input exp_t ex);
    int i;
    if (push) exp_q.push_back(ex);
    cmd_dx    = dx;
    cmd_dy    = dy;
    cmd_valid = 1'b1;
    @(negedge clk);
    i = 0;
    while (!cmd_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {cmd_ready, step_x, dir_x, step_y, dir_y, busy, done, aborted, steps_left}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_dx    = '0;
    cmd_dy    = '0;
    abort     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // dx=5, dy=-3: Y steps with X steps 2, 4, 5
    send(17'd5, 17'h1FFFD, 0, 1, mk(0, 5, 3, 'h1A, 53, 1, 0, 5, 0));
    wait_done();

    // zero move
    send(17'd0, 17'd0, 0, 1, mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    wait_done();

    // dx=dy=-4: four coincident pulses, both directions negative
    send(17'h1FFFC, 17'h1FFFC, 0, 1, mk(0, 4, 4, 'hF, 43, 0, 0, 4, 0));
    wait_done();

    // dx=0, dy=7 aborted in the middle of step 2's pulse
    send(17'd0, 17'd7, 0, 1, mk(1, 0, 2, 0, 16, 0, 1, 7, 6));
    repeat (13) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done();

    // reset during the GAP of a long move, then a one-step move
    send(17'd20, 17'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (7) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("midmove_reset_outputs_a");
    @(negedge clk);
    chk_all_zero("midmove_reset_outputs_b");
    @(posedge clk);
    #1 resetn = 1'b1;
    send(17'd1, 17'd0, 0, 1, mk(0, 1, 0, 0, 13, 1, 0, 1, 0));
    wait_done();

    // dx=-65536 with cmd_valid held, aborted after 3 steps; next command back-to-back
    send(17'h10000, 17'd0, 1, 1, mk(1, 3, 0, 0, 27, 0, 0, 65536, 65534));
    repeat (25) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    send(17'd2, 17'd1, 0, 1, mk(0, 2, 1, 'h2, 23, 1, 1, 2, 0));
    wait_done();

    repeat (20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
